// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed WAIT-cycle latency.
// Optional address checking is enabled with `define MEM_RESPONDER_ERR_EN.
module mem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 4) || (DEPTH > 4096) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("mem_responder: DEPTH must be a power of two in 4..4096");
    end
    if ((WAIT < 0) || (WAIT > 15)) begin : g_bad_wait
        $error("mem_responder: WAIT must be in 0..15");
    end

    // Handshake: a request is taken on any rising edge where reset=1, state is
    // IDLE and req=1; exactly one cycle with ready=1 follows WAIT+1 cycles later,
    // and rdata/err are meaningful only during that ready cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic            accept;
    logic            enter_resp;

    logic            lat_we;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;
    logic            lat_bad;
    logic            err_q;

    logic            in_bad;
    logic [AW-1:0]   in_idx;
    logic            txn_we;
    logic [AW-1:0]   txn_idx;
    logic [31:0]     txn_wdata;
    logic            txn_bad;

    logic [31:0]     mem [DEPTH];

    assign in_idx = addr[AW+1:2];

`ifdef MEM_RESPONDER_ERR_EN
    assign in_bad = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
`else
    // Byte offset and bits above the index are don't-care; addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign in_bad = 1'b0;
`endif

    // With WAIT=0 the RESP entry coincides with acceptance, so the live inputs
    // are used directly; otherwise the values latched at acceptance are used.
    always_comb begin
        txn_we    = lat_we;
        txn_idx   = lat_idx;
        txn_wdata = lat_wdata;
        txn_bad   = lat_bad;
        if (state == IDLE) begin
            txn_we    = we;
            txn_idx   = in_idx;
            txn_wdata = wdata;
            txn_bad   = in_bad;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT_ST;
                        cnt_nxt   = 4'(WAIT - 1);
                    end
                end
            end
            WAIT_ST: begin
                if (cnt == 4'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            err_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_bad   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= we;
                lat_idx   <= in_idx;
                lat_wdata <= wdata;
                lat_bad   <= in_bad;
            end
            if (enter_resp) begin
                err_q <= txn_bad;
                if (txn_bad) begin
                    rdata <= 32'd0;
                end else if (!txn_we) begin
                    rdata <= mem[txn_idx];
                end
            end
        end
    end

    // Memory has no reset; a reset edge blocks the commit of a pending write.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && txn_we && !txn_bad) begin
            mem[txn_idx] <= txn_wdata;
        end
    end

    assign ready     = (state == RESP);
    assign busy      = (state != IDLE);
    assign err       = ready & err_q;
    assign fsm_state = state;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words; it SHALL be a power of two between 4 and 4096.
REQ-002 SHALL have parameter WAIT, default 2, meaning the wait cycles inserted before the response; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low, sampled on the rising edge of clk.
REQ-005 SHALL have port req, input, 1 bit: CPU request valid (the CPU-side memory enable).
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: write data.
REQ-009 SHALL have port rdata, output, 32 bits: read data, valid while ready=1.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port err, output, 1 bit: error flag, qualified by ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_ST and RESP; busy SHALL equal (state != IDLE).
REQ-014 In IDLE with req=1 at a clock edge, SHALL accept the request by latching we, addr and wdata; inputs SHALL be ignored in every other state.
REQ-015 On acceptance, SHALL go to RESP if WAIT=0; otherwise SHALL go to WAIT_ST with the counter loaded to WAIT-1.
REQ-016 In WAIT_ST, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-017 On the edge entering RESP, a write SHALL commit latched wdata to mem[word index], and a read SHALL register mem[word index] into rdata.
REQ-018 In RESP, ready SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-019 ready SHALL go high WAIT+1 cycles after the acceptance edge; back-to-back requests SHALL therefore start WAIT+2 cycles apart.
REQ-020 A req still high during RESP SHALL NOT be accepted in that cycle; it SHALL be accepted on the first IDLE cycle.
REQ-021 The word index SHALL be addr[log2(DEPTH)+1:2].
REQ-022 A read to the address of the immediately preceding write SHALL return the newly written value.
REQ-023 rdata SHALL hold its last value outside RESP, and SHALL keep its previous value after a write.
REQ-024 Memory contents SHALL NOT be reset.

Reset
REQ-025 With reset=0 at an edge, SHALL set state=IDLE, counter=0, ready=0, busy=0, err=0 and rdata=0.
REQ-026 A reset in WAIT_ST SHALL abort the transaction, and any latched write SHALL NOT be committed.
REQ-027 A reset in RESP SHALL force ready=0 on the following cycle.
REQ-028 req SHALL NOT be accepted on an edge where reset=0.

Configuration
REQ-029 Macro MEM_RESPONDER_ERR_EN defined: a request with addr[1:0]!=0 or addr >= DEPTH*4 SHALL complete with normal latency, with err=1 and rdata=0 in RESP, and any write SHALL be suppressed.
REQ-030 Macro MEM_RESPONDER_ERR_EN undefined: err SHALL be tied to 0, addr[1:0] and the upper address bits SHALL be ignored, and addresses SHALL alias modulo DEPTH*4.

Verification
REQ-031 With WAIT=2, write addr=0x10, wdata=0xDEADBEEF accepted at cycle 0 -> busy=1 in cycles 1-3; ready=1 only in cycle 3; err=0.
REQ-032 A read of addr=0x10 on the first IDLE cycle after REQ-031 -> ready=1 three cycles later with rdata=0xDEADBEEF.
REQ-033 With WAIT=0, req held high continuously with reads of 0x0, 0x4, 0x8 -> ready pulses every 2 cycles and three distinct completions.
REQ-034 A write of 0x12345678 to 0x20, with reset=0 in the WAIT_ST cycle -> ready never asserts; a later read of 0x20 returns its prior value (0xDEADBEEF if preloaded).
REQ-035 ERR_EN defined, write to 0x13 then a write to 0x100 (DEPTH=64) -> both complete with err=1 and ready=1, and mem is unchanged; ERR_EN undefined, a write to 0x100 aliases to word 0 (read of 0x0 returns the written data).
REQ-036 Toggling addr and wdata during WAIT_ST -> the latched values are used and the response is unaffected.
